// File: rtl/mnist_pkg.sv
// Shared constants and types for the MNIST inference pipeline front end.
package mnist_pkg;

  // Image geometry and pixel format
  localparam int PIX_W  = 8;
  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;

  // Frame sync word, MSB received first
  localparam int                SYNC_W    = 8;
  localparam logic [SYNC_W-1:0] SYNC_WORD = 8'hA5;

  // Consecutive idle cycles tolerated inside a frame before it is abandoned
  localparam int TIMEOUT = 1023;

  // Deserializer control states
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bit_shift_reg.sv
// Serial-in / parallel-out shift register, MSB first, with shift enable
// and synchronous clear (clear wins over shift).
module bit_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         din,
  output logic [W-1:0] q
);

  // Shift the new bit in at the LSB so the first bit received ends up at the MSB.
  // NOTE: registers are assigned with <= so every flop samples pre-edge values;
  // the register is small, so it is reset rather than left uninitialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[W-2:0], din};
    end
  end

endmodule

// File: rtl/pixel_deserializer.sv
// Front end of the MNIST pipeline: hunts the frame sync word on the serial
// input, then assembles IMG_H*IMG_W pixels MSB first and presents each one
// with its row/column and frame start/done/error markers.
module pixel_deserializer #(
  parameter int                PIX_W     = mnist_pkg::PIX_W,
  parameter int                IMG_W     = mnist_pkg::IMG_W,
  parameter int                IMG_H     = mnist_pkg::IMG_H,
  parameter int                SYNC_W    = mnist_pkg::SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD = mnist_pkg::SYNC_WORD,
  parameter int                TIMEOUT   = mnist_pkg::TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in,
  input  logic             data_valid,
  output logic [PIX_W-1:0] pixel_out,
  output logic             pixel_valid,
  output logic [4:0]       pixel_row,
  output logic [4:0]       pixel_col,
  output logic             frame_start,
  output logic             frame_done,
  output logic             frame_err,
  output logic             busy
);

  import mnist_pkg::*;

  localparam int NUM_PIX   = IMG_H * IMG_W;
  localparam int BIT_CNT_W = $clog2(PIX_W);
  localparam int PIX_CNT_W = $clog2(NUM_PIX);
  localparam int TO_W      = $clog2(TIMEOUT + 1);

  state_t                 state;
  logic [SYNC_W-1:0]      sync_q;
  logic [PIX_W-1:0]       pix_q;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [PIX_CNT_W-1:0]   pix_cnt;
  logic [4:0]             row_cnt;
  logic [4:0]             col_cnt;
  logic [TO_W-1:0]        to_cnt;

  logic                   sync_en;
  logic                   sync_hit;
  logic                   recv_bit;
  logic                   bit_last;
  logic                   pix_done;
  logic                   frame_last;
  logic                   timeout_hit;
  logic                   window_msbs_unused;

  // The current bit completes both windows, so the oldest stored bit of each
  // register falls out of the window and is never looked at.
  assign window_msbs_unused = sync_q[SYNC_W-1] ^ pix_q[PIX_W-1];

  // Sync detection includes the bit being sampled this cycle
  assign sync_en  = (state == HUNT) && data_valid;
  assign sync_hit = sync_en && ({sync_q[SYNC_W-2:0], data_in} == SYNC_WORD);

  // Pixel assembly and frame progress
  assign recv_bit    = (state == RECV) && data_valid;
  assign bit_last    = (bit_cnt == BIT_CNT_W'(PIX_W - 1));
  assign pix_done    = recv_bit && bit_last;
  assign frame_last  = pix_done && (pix_cnt == PIX_CNT_W'(NUM_PIX - 1));
  assign timeout_hit = (state == RECV) && !data_valid && (to_cnt == TO_W'(TIMEOUT - 1));

  assign busy = (state != HUNT);

  // Sync window: only advances while hunting, emptied once the frame is entered
  bit_shift_reg #(.W(SYNC_W)) u_sync_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sync_en),
    .clr   (sync_hit),
    .din   (data_in),
    .q     (sync_q)
  );

  // Pixel assembly: holds across idle cycles, partial pixel dropped on abort
  bit_shift_reg #(.W(PIX_W)) u_pix_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (recv_bit),
    .clr   (sync_hit || timeout_hit),
    .din   (data_in),
    .q     (pix_q)
  );

  // Control FSM: hunt for sync, receive one frame, one-cycle DONE marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
    end else begin
      case (state)
        HUNT:    if (sync_hit) state <= RECV;
        RECV:    if (frame_last) state <= DONE;
                 else if (timeout_hit) state <= HUNT;
        DONE:    state <= HUNT;
        default: state <= HUNT;
      endcase
    end
  end

  // Bit, pixel, coordinate and idle counters; all start fresh on each sync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      pix_cnt <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      to_cnt  <= '0;
    end else if (sync_hit || timeout_hit) begin
      bit_cnt <= '0;
      pix_cnt <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      to_cnt  <= '0;
    end else if (state == RECV) begin
      if (data_valid) begin
        to_cnt  <= '0;
        bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
        if (bit_last) begin
          pix_cnt <= pix_cnt + 1'b1;
          if (col_cnt == 5'(IMG_W - 1)) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + 1'b1;
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // Output registers: pixel data/coords held between strobes, markers pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_out   <= '0;
      pixel_row   <= '0;
      pixel_col   <= '0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      pixel_valid <= pix_done;
      frame_start <= pix_done && (pix_cnt == '0);
      frame_done  <= (state == DONE);
      frame_err   <= timeout_hit;
      if (pix_done) begin
        pixel_out <= {pix_q[PIX_W-2:0], data_in};
        pixel_row <= row_cnt;
        pixel_col <= col_cnt;
      end
    end
  end

endmodule

// File: tb/tb_pixel_deserializer.sv
// Self-checking bench for pixel_deserializer: frames of random or patterned
// pixels are serialised, and the observed pixel stream, coordinates and
// frame markers are compared with a reference frame built in the bench.
`timescale 1ns/1ps
module tb_pixel_deserializer;

  import mnist_pkg::*;

  localparam int NUM_PIX = IMG_W * IMG_H;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             data_in = 1'b0;
  logic             data_valid = 1'b0;
  logic [PIX_W-1:0] pixel_out;
  logic             pixel_valid;
  logic [4:0]       pixel_row;
  logic [4:0]       pixel_col;
  logic             frame_start;
  logic             frame_done;
  logic             frame_err;
  logic             busy;

  pixel_deserializer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .pixel_row   (pixel_row),
    .pixel_col   (pixel_col),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed pixel record: frame_start, row, col, value
  typedef struct packed {
    logic             start;
    logic [4:0]       row;
    logic [4:0]       col;
    logic [PIX_W-1:0] val;
  } pix_t;

  pix_t obs_q[$];
  int   obs_cyc[$];
  int   done_cyc[$];
  int   err_cyc[$];
  int   strays = 0;

  // Reference frame content
  logic [PIX_W-1:0] exp_pix [NUM_PIX];

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor: outputs are sampled on the falling edge, away from updates
  always @(negedge clk) begin
    if (pixel_valid) begin
      obs_q.push_back({frame_start, pixel_row, pixel_col, pixel_out});
      obs_cyc.push_back(cyc);
    end else if (frame_start) begin
      strays++;
    end
    if (frame_done) done_cyc.push_back(cyc);
    if (frame_err)  err_cyc.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    obs_q.delete();
    obs_cyc.delete();
    done_cyc.delete();
    err_cyc.delete();
    strays = 0;
  endtask

  task automatic drive(input logic v, input logic d);
    @(negedge clk);
    data_valid = v;
    data_in    = d;
  endtask

  // Idle cycles carry random junk on data_in to show it is ignored
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)));
  endtask

  // Send nbits of w, MSB first, with optional short random gaps before bits
  task automatic send_word(input logic [31:0] w, input int nbits, input int gap_max);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (gap_max > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, gap_max));
      drive(1'b1, w[i]);
    end
  endtask

  task automatic send_pixels(input int first, input int last, input int gap_max);
    for (int i = first; i <= last; i++) send_word(32'(exp_pix[i]), PIX_W, gap_max);
  endtask

  task automatic send_frame(input int gap_max);
    send_word(32'(SYNC_WORD), SYNC_W, 0);
    send_pixels(0, NUM_PIX - 1, gap_max);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NUM_PIX; i++) exp_pix[i] = PIX_W'($urandom);
  endtask

  // Compare the observed stream against nframes copies of the reference frame
  task automatic check_frames(input string tag, input int nframes);
    int n_exp;
    n_exp = nframes * NUM_PIX;
    idle(4);
    check({tag, " pixel count"}, obs_q.size(), n_exp);
    for (int i = 0; i < obs_q.size() && i < n_exp; i++) begin
      int   p;
      pix_t e;
      p = i % NUM_PIX;
      e = {(p == 0), 5'(p / IMG_W), 5'(p % IMG_W), exp_pix[p]};
      check($sformatf("%s pixel %0d", tag, i), 32'(obs_q[i]), 32'(e));
    end
    check({tag, " frame_done count"}, done_cyc.size(), nframes);
    for (int f = 0; f < done_cyc.size() && f < nframes; f++) begin
      if (obs_cyc.size() >= (f + 1) * NUM_PIX)
        check($sformatf("%s frame_done %0d timing", tag, f), done_cyc[f],
              obs_cyc[(f + 1) * NUM_PIX - 1] + 1);
    end
    check({tag, " frame_err count"}, err_cyc.size(), 0);
    check({tag, " stray frame_start"}, strays, 0);
    check({tag, " busy idle"}, busy, 0);
  endtask

  initial begin
    int t0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset pixel_out", pixel_out, 0);
    check("reset pixel_valid", pixel_valid, 0);
    check("reset row/col", {pixel_row, pixel_col}, 0);
    check("reset markers", {frame_start, frame_done, frame_err}, 0);
    check("reset busy", busy, 0);
    rst_n = 1'b1;
    idle(3);

    // 1: continuous frame, pixel i = i mod 256
    for (int i = 0; i < NUM_PIX; i++) exp_pix[i] = PIX_W'(i % 256);
    clear_mon();
    send_frame(0);
    check_frames("s1", 1);

    // 2: same frame with random short gaps plus one gap of TIMEOUT-1 mid-pixel
    clear_mon();
    send_word(32'(SYNC_WORD), SYNC_W, 0);
    send_pixels(0, 299, 5);
    send_word(32'(exp_pix[300] >> 4), 4, 0);
    idle(TIMEOUT - 1);
    send_word(32'(exp_pix[300]), 4, 0);
    send_pixels(301, NUM_PIX - 1, 5);
    check_frames("s2", 1);

    // 3: random pixels containing the sync word, aligned and straddling pixels
    fill_random();
    exp_pix[0]   = SYNC_WORD;
    exp_pix[5]   = SYNC_WORD;
    exp_pix[100] = SYNC_WORD;
    exp_pix[200] = 8'h0A;
    exp_pix[201] = 8'h5F;
    exp_pix[NUM_PIX-1] = SYNC_WORD;
    clear_mon();
    send_word(32'(SYNC_WORD), SYNC_W, 0);
    idle(1);
    check("s3 busy after sync", busy, 1);
    send_pixels(0, NUM_PIX - 1, 2);
    check_frames("s3", 1);

    // 4: stall after pixel 100 plus a partial pixel, expect abort after TIMEOUT
    fill_random();
    clear_mon();
    send_word(32'(SYNC_WORD), SYNC_W, 0);
    send_pixels(0, 100, 0);
    send_word(32'b101, 3, 0);
    @(negedge clk);
    t0 = cyc;
    data_valid = 1'b0;
    idle(TIMEOUT + 2);
    check("s4 frame_err count", err_cyc.size(), 1);
    if (err_cyc.size() > 0) check("s4 frame_err timing", err_cyc[0], t0 + TIMEOUT);
    check("s4 pixels before abort", obs_q.size(), 101);
    if (obs_q.size() > 100)
      check("s4 pixel 100", 32'(obs_q[100]), 32'({1'b0, 5'(100 / IMG_W), 5'(100 % IMG_W), exp_pix[100]}));
    check("s4 no frame_done", done_cyc.size(), 0);
    check("s4 busy after abort", busy, 0);
    fill_random();
    clear_mon();
    send_frame(0);
    check_frames("s4 restart", 1);

    // 5: reset mid-pixel, then a clean frame
    fill_random();
    exp_pix[39] = 8'hFF;
    clear_mon();
    send_word(32'(SYNC_WORD), SYNC_W, 0);
    send_pixels(0, 39, 0);
    send_word(32'b110, 3, 0);
    @(negedge clk);
    check("s5 pixel_out before reset", pixel_out, 8'hFF);
    rst_n = 1'b0;
    data_valid = 1'b0;
    #1;
    check("s5 reset pixel_out", pixel_out, 0);
    check("s5 reset row/col", {pixel_row, pixel_col}, 0);
    check("s5 reset strobes", {pixel_valid, frame_start, frame_done, frame_err}, 0);
    check("s5 reset busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    check("s5 no frame_done", done_cyc.size(), 0);
    check("s5 no frame_err", err_cyc.size(), 0);
    fill_random();
    clear_mon();
    send_frame(1);
    check_frames("s5 after reset", 1);

    // 6: back-to-back frames; the bit offered during DONE must be ignored
    fill_random();
    clear_mon();
    send_frame(0);
    drive(1'b1, 1'b1);
    send_frame(0);
    check_frames("s6", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
